// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register.
// An IDLE -> GRANT -> WRITE sequence loads one requester's data slice into q per round.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [IDW-1:0]        last_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t           state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_valid_reg, q_valid_next;
  logic [IDW-1:0]   last_id_reg, last_id_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   win_reg, win_next;
  logic [IDW-1:0]   sel;
  logic [IDW:0]     cand;
  logic [WIDTH-1:0] slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // Scan from ptr-1 down to ptr (with wrap) so the nearest set bit at or above ptr wins last.
  always_comb begin
    sel  = ptr_reg;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (req[cand[IDW-1:0]]) sel = cand[IDW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      last_id_reg <= '0;
      ptr_reg     <= '0;
      win_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      q_reg       <= q_next;
      q_valid_reg <= q_valid_next;
      last_id_reg <= last_id_next;
      ptr_reg     <= ptr_next;
      win_reg     <= win_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_next     = '0;
    q_next       = q_reg;
    q_valid_next = 1'b0;
    last_id_next = last_id_reg;
    ptr_next     = ptr_reg;
    win_next     = win_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          win_next   = sel;
          gnt_next   = NREQ'(1) << sel;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // A winner that dropped its request forfeits the round without touching q or ptr.
        if (req[win_reg]) begin
          q_next       = slice[win_reg];
          last_id_next = win_reg;
          q_valid_next = 1'b1;
          ptr_next     = (win_reg == IDW'(NREQ - 1)) ? '0 : win_reg + IDW'(1);
          state_next   = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign gnt     = gnt_reg;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign last_id = last_id_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: per-cycle vector table plus reset sequences.
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b1111;
  logic [31:0] wdata = 32'h44332211;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  last_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic prev_qv = 1'b0;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .last_id(last_id), .busy(busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  last;
    logic        busy;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".gnt"}, 32'(gnt), 32'(v.gnt));
    check({tag, ".q"}, 32'(q), 32'(v.q));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(v.qv));
    check({tag, ".last_id"}, 32'(last_id), 32'(v.last));
    check({tag, ".busy"}, 32'(busy), 32'(v.busy));
  endtask

  // Structural invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv_qv_no_repeat", 32'(prev_qv && q_valid), 32'd0);
      prev_qv <= q_valid;
    end else begin
      prev_qv <= 1'b0;
    end
  end

  initial begin
    vec_t rv;
    // Round robin over all four (ptr starts at 0, requester 0 already granted).
    vecs[0]  = '{4'b1111, 32'h44332211, 4'b0000, 8'h11, 1'b1, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 32'h44332211, 4'b0000, 8'h11, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{4'b1111, 32'h44332211, 4'b0010, 8'h11, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{4'b1111, 32'h44332211, 4'b0000, 8'h22, 1'b1, 2'd1, 1'b1};
    vecs[4]  = '{4'b1111, 32'h44332211, 4'b0000, 8'h22, 1'b0, 2'd1, 1'b0};
    vecs[5]  = '{4'b1111, 32'h44332211, 4'b0100, 8'h22, 1'b0, 2'd1, 1'b1};
    vecs[6]  = '{4'b1111, 32'h44332211, 4'b0000, 8'h33, 1'b1, 2'd2, 1'b1};
    vecs[7]  = '{4'b1111, 32'h44332211, 4'b0000, 8'h33, 1'b0, 2'd2, 1'b0};
    vecs[8]  = '{4'b1111, 32'h44332211, 4'b1000, 8'h33, 1'b0, 2'd2, 1'b1};
    vecs[9]  = '{4'b1111, 32'h44332211, 4'b0000, 8'h44, 1'b1, 2'd3, 1'b1};
    vecs[10] = '{4'b1111, 32'h44332211, 4'b0000, 8'h44, 1'b0, 2'd3, 1'b0};
    vecs[11] = '{4'b1111, 32'h44332211, 4'b0001, 8'h44, 1'b0, 2'd3, 1'b1};
    vecs[12] = '{4'b1111, 32'h44332211, 4'b0000, 8'h11, 1'b1, 2'd0, 1'b1};
    vecs[13] = '{4'b0000, 32'h44332211, 4'b0000, 8'h11, 1'b0, 2'd0, 1'b0};
    // Single requester 2 from ptr=1.
    vecs[14] = '{4'b0100, 32'h44A52211, 4'b0100, 8'h11, 1'b0, 2'd0, 1'b1};
    vecs[15] = '{4'b0100, 32'h44A52211, 4'b0000, 8'hA5, 1'b1, 2'd2, 1'b1};
    vecs[16] = '{4'b0000, 32'h44A52211, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0};
    // Wrap: ptr=3, requesters 0 and 1 -> 0 wins.
    vecs[17] = '{4'b0011, 32'h44A52211, 4'b0001, 8'hA5, 1'b0, 2'd2, 1'b1};
    vecs[18] = '{4'b0011, 32'h44A52211, 4'b0000, 8'h11, 1'b1, 2'd0, 1'b1};
    vecs[19] = '{4'b0010, 32'h44A52211, 4'b0000, 8'h11, 1'b0, 2'd0, 1'b0};
    vecs[20] = '{4'b0010, 32'h44A52211, 4'b0010, 8'h11, 1'b0, 2'd0, 1'b1};
    // Abort: requester 1 drops req during GRANT.
    vecs[21] = '{4'b0000, 32'h4433EE11, 4'b0000, 8'h11, 1'b0, 2'd0, 1'b0};
    // ptr must still be 1, so 1 beats 2.
    vecs[22] = '{4'b0110, 32'h4433EE11, 4'b0010, 8'h11, 1'b0, 2'd0, 1'b1};
    vecs[23] = '{4'b0110, 32'h4433EE11, 4'b0000, 8'hEE, 1'b1, 2'd1, 1'b1};
    vecs[24] = '{4'b0000, 32'h4433EE11, 4'b0000, 8'hEE, 1'b0, 2'd1, 1'b0};
    vecs[25] = '{4'b0000, 32'h4433EE11, 4'b0000, 8'hEE, 1'b0, 2'd1, 1'b0};
    // Unknown data on the losing slices must not reach q.
    vecs[26] = '{4'b1000, 32'h5Axxxxxx, 4'b1000, 8'hEE, 1'b0, 2'd1, 1'b1};
    vecs[27] = '{4'b1000, 32'h5Axxxxxx, 4'b0000, 8'h5A, 1'b1, 2'd3, 1'b1};
    vecs[28] = '{4'b0000, 32'h5Axxxxxx, 4'b0000, 8'h5A, 1'b0, 2'd3, 1'b0};

    // Reset held with all requesters active.
    rv = '{4'b1111, 32'h44332211, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_outs($sformatf("reset_c%0d", c), rv);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    rv = '{4'b1111, 32'h44332211, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b1};
    check_outs("release", rv);
    $display("release: gnt=%b q=%h busy=%b", gnt, q, busy);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req   = vecs[i].req;
      wdata = vecs[i].wdata;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i]);
      $display("vec%0d: req=%b gnt=%b q=%h qv=%b last=%0d busy=%b",
               i, req, gnt, q, q_valid, last_id, busy);
    end

    // Asynchronous reset during GRANT with FF pending.
    @(negedge clk);
    req   = 4'b0001;
    wdata = 32'h000000FF;
    @(posedge clk); #1;
    check("midrst.gnt_before", 32'(gnt), 32'h1);
    #2 reset = 1'b1;
    #1;
    rv = '{4'b0001, 32'h000000FF, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0};
    check_outs("midrst.immediate", rv);
    @(posedge clk); #1;
    check_outs("midrst.held", rv);
    @(negedge clk);
    req   = 4'b0000;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("midrst.after_q%0d", c), 32'(q), 32'h00);
      check($sformatf("midrst.after_qv%0d", c), 32'(q_valid), 32'h0);
    end
    $display("midrst: q=%h qv=%b busy=%b", q, q_valid, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
